pe_accum_ctrl: RTL and testbench



---
 rtl/pe_accum_ctrl_if.sv | 28 ++
 rtl/pe_accum_ctrl.sv | 131 +++++++++++++
 tb/tb_pe_accum_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_accum_ctrl_if.sv
// Channel bundle for pe_accum_ctrl: product input, upstream psum input and
// downstream psum output, each a valid/ready handshake.
interface pe_accum_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = WIDTH + 2
);
  logic                 prod_valid;
  logic                 prod_ready;
  logic [WIDTH-1:0]     prod_data;

  logic                 psum_in_valid;
  logic                 psum_in_ready;
  logic [ACC_WIDTH-1:0] psum_in_data;

  logic                 psum_out_valid;
  logic                 psum_out_ready;
  logic [ACC_WIDTH-1:0] psum_out_data;

  modport master (
    output prod_valid, prod_data, psum_in_valid, psum_in_data, psum_out_ready,
    input  prod_ready, psum_in_ready, psum_out_valid, psum_out_data
  );

  modport slave (
    input  prod_valid, prod_data, psum_in_valid, psum_in_data, psum_out_ready,
    output prod_ready, psum_in_ready, psum_out_valid, psum_out_data
  );
endinterface

// File: rtl/pe_accum_ctrl.sv
// Sequencer time-sharing one PE adder between tap accumulation and psum merge;
// emits NUM_OUTPUTS merged results per start.
module pe_accum_ctrl #(
  parameter  int WIDTH       = 8,
  parameter  int ACC_WIDTH   = WIDTH + 2,
  parameter  int NUM_TAPS    = 3,
  parameter  int NUM_OUTPUTS = 2,
  localparam int TW          = $clog2(NUM_TAPS + 1),
  localparam int OW          = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    sel,
  pe_accum_ctrl_if.slave bus,
  output logic [TW-1:0] tap_cnt,
  output logic [OW-1:0] out_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_PSUM,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);
  localparam logic [OW-1:0] LAST_OUT = OW'(NUM_OUTPUTS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_result;
  logic [TW-1:0]        r_tap_cnt;
  logic [OW-1:0]        r_out_cnt;

  logic                 w_prod_xfer;
  logic                 w_psum_xfer;
  logic                 w_out_xfer;
  logic [ACC_WIDTH-1:0] w_prod_ext;

  // Transfers are qualified by state, so the Moore readies never feed back.
  assign w_prod_xfer = (r_state == S_ACCUM) && bus.prod_valid;
  assign w_psum_xfer = (r_state == S_PSUM)  && bus.psum_in_valid;
  assign w_out_xfer  = (r_state == S_OUT)   && bus.psum_out_ready;
  assign w_prod_ext  = {{(ACC_WIDTH - WIDTH){1'b0}}, bus.prod_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACCUM;
      S_ACCUM: if (w_prod_xfer && (r_tap_cnt == LAST_TAP)) w_next = S_PSUM;
      S_PSUM:  if (w_psum_xfer) w_next = S_OUT;
      S_OUT:   if (w_out_xfer) w_next = (r_out_cnt == LAST_OUT) ? S_DONE : S_ACCUM;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy               = 1'b0;
    done               = 1'b0;
    sel                = 2'b00;
    bus.prod_ready     = 1'b0;
    bus.psum_in_ready  = 1'b0;
    bus.psum_out_valid = 1'b0;
    bus.psum_out_data  = '0;
    case (r_state)
      S_ACCUM: begin
        busy           = 1'b1;
        sel            = 2'b01;
        bus.prod_ready = 1'b1;
      end
      S_PSUM: begin
        busy              = 1'b1;
        sel               = 2'b10;
        bus.psum_in_ready = 1'b1;
      end
      S_OUT: begin
        busy               = 1'b1;
        bus.psum_out_valid = 1'b1;
        bus.psum_out_data  = r_result;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_result  <= '0;
      r_tap_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_acc     <= '0;
          r_tap_cnt <= '0;
          r_out_cnt <= '0;
        end
        S_ACCUM: if (w_prod_xfer) begin
          r_acc     <= r_acc + w_prod_ext;
          r_tap_cnt <= r_tap_cnt + TW'(1);
        end
        S_PSUM: if (w_psum_xfer) r_result <= r_acc + bus.psum_in_data;
        S_OUT: if (w_out_xfer) begin
          r_out_cnt <= r_out_cnt + OW'(1);
          r_acc     <= '0;
          r_tap_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign tap_cnt = r_tap_cnt;
  assign out_cnt = r_out_cnt;

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// Self-checking bench for pe_accum_ctrl: directed scenarios plus randomized
// passes checked against a sum-of-products reference model.
module tb_pe_accum_ctrl;
  localparam int WIDTH = 8;
  localparam int ACC_WIDTH = 10;
  localparam int NT = 3;
  localparam int NO = 2;
  localparam int BOUND = 50;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic [1:0] sel;
  logic [1:0] tap_cnt;
  logic [1:0] out_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  pe_accum_ctrl_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  pe_accum_ctrl #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .NUM_TAPS(NT), .NUM_OUTPUTS(NO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .sel(sel), .bus(bus), .tap_cnt(tap_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference: result is the plain sum of all taps plus the psum, modulo 2^ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] model_sum(input logic [7:0] p [NT],
                                                     input logic [ACC_WIDTH-1:0] ps);
    int unsigned s;
    s = ps;
    for (int i = 0; i < NT; i++) s += p[i];
    return ACC_WIDTH'(s % (1 << ACC_WIDTH));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_prod(input logic [7:0] d, input int unsigned gap);
    int unsigned n;
    for (int unsigned g = 0; g < gap; g++) begin
      bus.prod_valid = 1'b0;
      bus.prod_data  = 8'($urandom);
      step();
    end
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    n = 0;
    while (!bus.prod_ready && n < BOUND) begin step(); n++; end
    checks++;
    if (!bus.prod_ready) begin
      errors++;
      $display("FAIL prod_timeout: prod_ready=%b required 1", bus.prod_ready);
    end
    step();
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
  endtask

  task automatic send_psum(input logic [ACC_WIDTH-1:0] d);
    int unsigned n;
    bus.psum_in_valid = 1'b1;
    bus.psum_in_data  = d;
    n = 0;
    while (!bus.psum_in_ready && n < BOUND) begin step(); n++; end
    checks++;
    if (!bus.psum_in_ready) begin
      errors++;
      $display("FAIL psum_in_timeout: psum_in_ready=%b required 1", bus.psum_in_ready);
    end
    step();
    bus.psum_in_valid = 1'b0;
    bus.psum_in_data  = '0;
  endtask

  task automatic recv_out(input int unsigned stall, output logic [ACC_WIDTH-1:0] d);
    int unsigned n;
    bus.psum_out_ready = 1'b0;
    n = 0;
    while (!bus.psum_out_valid && n < BOUND) begin step(); n++; end
    checks++;
    if (!bus.psum_out_valid) begin
      errors++;
      $display("FAIL psum_out_timeout: psum_out_valid=%b required 1", bus.psum_out_valid);
    end
    for (int unsigned s = 0; s < stall; s++) step();
    bus.psum_out_ready = 1'b1;
    d = bus.psum_out_data;
    step();
    bus.psum_out_ready = 1'b0;
  endtask

  task automatic do_output(input logic [7:0] p [NT], input logic [ACC_WIDTH-1:0] ps,
                           input int unsigned maxgap, input int unsigned stall,
                           output logic [ACC_WIDTH-1:0] got);
    for (int i = 0; i < NT; i++) send_prod(p[i], $urandom_range(maxgap, 0));
    send_psum(ps);
    recv_out(stall, got);
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic random_output(input string name);
    logic [7:0] p [NT];
    logic [ACC_WIDTH-1:0] ps, got, exp;
    for (int i = 0; i < NT; i++) p[i] = 8'($urandom);
    ps  = ACC_WIDTH'($urandom);
    exp = model_sum(p, ps);
    do_output(p, ps, 2, $urandom_range(3, 0), got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: psum_out_data=%0d required %0d", name, got, exp);
    end
  endtask

  task automatic finish_pass(input string name);
    checks++;
    if ({done, busy, sel} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_done_state: done/busy/sel=%b required 1100", name, {done, busy, sel});
    end
    step();
    checks++;
    if ({done, busy, sel} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_idle_state: done/busy/sel=%b required 0000", name, {done, busy, sel});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, sel, bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/sel/readies/valid=%b required 0000000",
               {busy, done, sel, bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid});
    end
    checks++;
    if ({tap_cnt, out_cnt, bus.psum_out_data} !== 14'b0) begin
      errors++;
      $display("FAIL reset_cnt: tap=%0d out=%0d data=%0d required 0 0 0",
               tap_cnt, out_cnt, bus.psum_out_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] p [NT];
    logic [ACC_WIDTH-1:0] got;
    int d0;
    d0 = done_cnt;
    start_pass();
    checks++;
    if ({busy, sel, bus.prod_ready, tap_cnt, out_cnt} !== 8'b1_01_1_00_00) begin
      errors++;
      $display("FAIL basic_accum_entry: busy/sel/prod_ready/tap/out=%b required 10110000",
               {busy, sel, bus.prod_ready, tap_cnt, out_cnt});
    end
    send_prod(8'd1, 0);
    send_prod(8'd2, 0);
    send_prod(8'd3, 0);
    checks++;
    if ({sel, bus.psum_in_ready, bus.prod_ready, tap_cnt} !== 6'b10_1_0_11) begin
      errors++;
      $display("FAIL basic_psum_state: sel/psum_in_ready/prod_ready/tap=%b required 101011",
               {sel, bus.psum_in_ready, bus.prod_ready, tap_cnt});
    end
    send_psum(10'd10);
    checks++;
    if ({bus.psum_out_valid, bus.psum_out_data, sel} !== {1'b1, 10'd16, 2'b00}) begin
      errors++;
      $display("FAIL basic_out_state: valid=%b data=%0d sel=%b required 1 16 00",
               bus.psum_out_valid, bus.psum_out_data, sel);
    end
    recv_out(0, got);
    checks++;
    if (got !== 10'd16 || out_cnt !== 2'd1 || tap_cnt !== 2'd0) begin
      errors++;
      $display("FAIL basic_out0: data=%0d out=%0d tap=%0d required 16 1 0", got, out_cnt, tap_cnt);
    end
    p = '{8'd4, 8'd5, 8'd6};
    do_output(p, 10'd0, 0, 0, got);
    checks++;
    if (got !== 10'd15) begin
      errors++;
      $display("FAIL basic_out1: psum_out_data=%0d required 15", got);
    end
    finish_pass("basic");
    checks++;
    if (out_cnt !== 2'd2 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL basic_done_count: out_cnt=%0d done_pulses=%0d required 2 1", out_cnt, done_cnt - d0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] p [NT];
    logic [ACC_WIDTH-1:0] got;
    start_pass();
    p = '{8'd255, 8'd255, 8'd255};
    do_output(p, 10'd300, 0, 0, got);
    checks++;
    if (got !== 10'd41) begin
      errors++;
      $display("FAIL overflow: psum_out_data=%0d required 41", got);
    end
    random_output("overflow_out1");
    finish_pass("overflow");
  endtask

  task automatic test_backpressure();
    logic [7:0] p [NT];
    logic [ACC_WIDTH-1:0] exp;
    start_pass();
    for (int i = 0; i < NT; i++) p[i] = 8'($urandom);
    exp = model_sum(p, 10'd77);
    for (int i = 0; i < NT; i++) send_prod(p[i], 0);
    send_psum(10'd77);
    bus.psum_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.psum_out_valid, bus.prod_ready, bus.psum_in_ready} !== 3'b100 ||
          bus.psum_out_data !== exp) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid/prod_ready/psum_in_ready=%b data=%0d required 100 %0d",
                 c, {bus.psum_out_valid, bus.prod_ready, bus.psum_in_ready}, bus.psum_out_data, exp);
      end
      step();
    end
    bus.psum_out_ready = 1'b1;
    step();
    bus.psum_out_ready = 1'b0;
    checks++;
    if ({bus.psum_out_valid, bus.psum_out_data, sel, out_cnt} !== {1'b0, 10'd0, 2'b01, 2'd1}) begin
      errors++;
      $display("FAIL backpressure_accept: valid=%b data=%0d sel=%b out=%0d required 0 0 01 1",
               bus.psum_out_valid, bus.psum_out_data, sel, out_cnt);
    end
    random_output("backpressure_out1");
    finish_pass("backpressure");
  endtask

  task automatic test_sparse();
    logic pat [6];
    logic [7:0] vals [3];
    logic [ACC_WIDTH-1:0] got;
    int k;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vals = '{8'd7, 8'd8, 8'd9};
    k = 0;
    start_pass();
    for (int c = 0; c < 6; c++) begin
      bus.prod_valid = pat[c];
      bus.prod_data  = pat[c] ? vals[k] : 8'($urandom);
      if (pat[c]) k++;
      step();
      checks++;
      if (k < NT) begin
        if (tap_cnt !== 2'(k) || sel !== 2'b01) begin
          errors++;
          $display("FAIL sparse_cycle[%0d]: tap=%0d sel=%b required %0d 01", c, tap_cnt, sel, k);
        end
      end else if (tap_cnt !== 2'd3 || sel !== 2'b10) begin
        errors++;
        $display("FAIL sparse_last: tap=%0d sel=%b required 3 10", tap_cnt, sel);
      end
    end
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    send_psum(10'd0);
    recv_out(0, got);
    checks++;
    if (got !== 10'd24) begin
      errors++;
      $display("FAIL sparse_result: psum_out_data=%0d required 24", got);
    end
    random_output("sparse_out1");
    finish_pass("sparse");
  endtask

  task automatic test_reset_mid();
    logic [7:0] p [NT];
    logic [ACC_WIDTH-1:0] got;
    start_pass();
    send_prod(8'd200, 0);
    send_prod(8'd100, 0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, sel, bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid, tap_cnt, out_cnt} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid_async: ctrl/cnt=%b required 0",
               {busy, done, sel, bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid, tap_cnt, out_cnt});
    end
    step();
    reset = 1'b0;
    step();
    start_pass();
    p = '{8'd1, 8'd1, 8'd1};
    do_output(p, 10'd0, 0, 0, got);
    checks++;
    if (got !== 10'd3) begin
      errors++;
      $display("FAIL reset_mid_residue: psum_out_data=%0d required 3", got);
    end
    random_output("reset_mid_out1");
    finish_pass("reset_mid");
  endtask

  task automatic test_start_ignored();
    logic [ACC_WIDTH-1:0] got, exp;
    logic [7:0] p [NT];
    int d0;
    d0 = done_cnt;
    start_pass();
    for (int i = 0; i < NT; i++) p[i] = 8'($urandom);
    exp = model_sum(p, 10'd5);
    start = 1'b1;
    for (int i = 0; i < NT; i++) send_prod(p[i], 0);
    start = 1'b0;
    send_psum(10'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    recv_out(0, got);
    checks++;
    if (got !== exp || out_cnt !== 2'd1) begin
      errors++;
      $display("FAIL start_ignored_out0: data=%0d out=%0d required %0d 1", got, out_cnt, exp);
    end
    random_output("start_ignored_out1");
    finish_pass("start_ignored");
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (busy !== 1'b0 || bus.psum_out_valid !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL start_ignored_tail: busy=%b valid=%b done_pulses=%0d required 0 0 1",
               busy, bus.psum_out_valid, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    start_pass();
    random_output("b2b_a0");
    random_output("b2b_a1");
    start = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || out_cnt !== 2'd2) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b out=%0d required 0 2", busy, out_cnt);
    end
    step();
    start = 1'b0;
    checks++;
    if ({busy, sel, tap_cnt, out_cnt} !== 7'b1_01_00_00) begin
      errors++;
      $display("FAIL b2b_restart: busy/sel/tap/out=%b required 1010000", {busy, sel, tap_cnt, out_cnt});
    end
    random_output("b2b_b0");
    random_output("b2b_b1");
    finish_pass("b2b");
  endtask

  task automatic test_random();
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      start_pass();
      for (int o = 0; o < NO; o++) random_output($sformatf("random_p%0d_o%0d", k, o));
      finish_pass("random");
      for (int unsigned g = $urandom_range(2, 0); g > 0; g--) step();
    end
    checks++;
    if (done_cnt - d0 !== 6) begin
      errors++;
      $display("FAIL random_done_pulses: %0d required 6", done_cnt - d0);
    end
  endtask

  initial begin
    reset              = 1'b1;
    start              = 1'b0;
    bus.prod_valid     = 1'b0;
    bus.prod_data      = '0;
    bus.psum_in_valid  = 1'b0;
    bus.psum_in_data   = '0;
    bus.psum_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
